// File: rtl/pipe_stall_sched_pkg.sv
// Shared encodings for the pipeline stall/flush scheduler: stall patterns, FSM states, helpers.
package pipe_stall_sched_pkg;

    // Stall vector bits: 0 PC, 1 IF, 2 IF/ID, 3 ID/EX, 4 EX/MEM, 5 MEM/WB
    localparam int BIT_EXMEM = 4;

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_LD  = 6'b000111;
    localparam logic [5:0] STALL_IF  = 6'b000011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LSU   = 2'd2
    } sched_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_port_wdog.sv
// Watchdog for the unified memory port: counts outstanding cycles, pulses port_err on expiry.
module pipe_port_wdog #(
    parameter int TO_CYC = 255,
    parameter int TO_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic expire,
    output logic port_err
);

    logic [TO_W-1:0] cnt;

    // cnt is 0 in the first outstanding cycle, so expiry lands on the TO_CYC-th cycle
    assign expire = active & ~done & (cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            port_err <= 1'b0;
        end else begin
            port_err <= expire;
            cnt      <= active ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/pipe_stall_sched.sv
// Stall/flush scheduler and IF/MEM port arbiter for the 5-stage pipeline.
// Optional cycle counters for each stall term when STALL_PERF_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | port free; MEM request wins over IF
//   ST_FETCH | instruction fetch outstanding on the port
//   ST_LSU   | load/store outstanding on the port
module pipe_stall_sched
    import pipe_stall_sched_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int TO_CYC  = 255,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic               mem_req,
    input  logic               id_ld_use,
    input  logic               ex_br_flush,
    input  logic               port_done,
    output logic [STALL_W-1:0] stall_sign,
    output logic               flush,
    output logic               port_start,
    output logic               grant_if,
    output logic               grant_mem,
    output logic               if_data_ok,
    output logic               port_err
`ifdef STALL_PERF_EN
   ,output logic [31:0]        perf_mem_stall,
    output logic [31:0]        perf_ld_stall,
    output logic [31:0]        perf_if_stall
`endif
);

    sched_state_e state;
    logic         discard;
    logic         active;
    logic         expire;
    logic         xact_end;
    logic         mem_term;
    logic         ld_term;
    logic         if_term;
    logic         fetch_hit;
    logic [5:0]   stall_vec;

    assign active    = (state != ST_IDLE);
    assign xact_end  = port_done | expire;

    assign mem_term  = mem_req & ~((state == ST_LSU) & port_done);
    assign ld_term   = id_ld_use;
    assign fetch_hit = (state == ST_FETCH) & port_done & ~discard;
    assign if_term   = if_req & ~fetch_hit;

    assign stall_vec = (mem_term ? STALL_MEM : 6'b0)
                     | (ld_term  ? STALL_LD  : 6'b0)
                     | (if_term  ? STALL_IF  : 6'b0);
    assign stall_sign = STALL_W'(stall_vec);

    // A branch sitting in a frozen EX stage must not redirect the PC yet
    assign flush      = ex_br_flush & ~stall_vec[BIT_EXMEM];
    assign if_data_ok = fetch_hit & ~flush;

    pipe_port_wdog #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .done     (port_done),
        .expire   (expire),
        .port_err (port_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_if   <= 1'b0;
            grant_mem  <= 1'b0;
            port_start <= 1'b0;
            discard    <= 1'b0;
        end else begin
            port_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state      <= ST_LSU;
                        grant_mem  <= 1'b1;
                        port_start <= 1'b1;
                    end else if (if_req) begin
                        state      <= ST_FETCH;
                        grant_if   <= 1'b1;
                        port_start <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (xact_end) begin
                        state    <= ST_IDLE;
                        grant_if <= 1'b0;
                        discard  <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                ST_LSU: begin
                    if (xact_end) begin
                        state     <= ST_IDLE;
                        grant_mem <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    grant_if  <= 1'b0;
                    grant_mem <= 1'b0;
                    discard   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mem_stall <= '0;
            perf_ld_stall  <= '0;
            perf_if_stall  <= '0;
        end else begin
            if (mem_term) perf_mem_stall <= sat_inc(perf_mem_stall);
            if (ld_term)  perf_ld_stall  <= sat_inc(perf_ld_stall);
            if (if_term)  perf_if_stall  <= sat_inc(perf_if_stall);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Directed scenarios plus randomized traffic for pipe_stall_sched against a transaction-level model.
module tb_pipe_stall_sched;

    localparam int TO_CYC = 255;

    logic       clk = 1'b0;
    logic       rst, if_req, mem_req, id_ld_use, ex_br_flush, port_done;
    logic [5:0] stall_sign;
    logic       flush, port_start, grant_if, grant_mem, if_data_ok, port_err;
`ifdef STALL_PERF_EN
    logic [31:0] perf_mem_stall, perf_ld_stall, perf_if_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stall_sched #(.STALL_W(6), .TO_CYC(TO_CYC), .TO_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .mem_req     (mem_req),
        .id_ld_use   (id_ld_use),
        .ex_br_flush (ex_br_flush),
        .port_done   (port_done),
        .stall_sign  (stall_sign),
        .flush       (flush),
        .port_start  (port_start),
        .grant_if    (grant_if),
        .grant_mem   (grant_mem),
        .if_data_ok  (if_data_ok),
        .port_err    (port_err)
`ifdef STALL_PERF_EN
       ,.perf_mem_stall (perf_mem_stall),
        .perf_ld_stall  (perf_ld_stall),
        .perf_if_stall  (perf_if_stall)
`endif
    );

    // Reference: one outstanding port transaction described by owner/age/killed
    int         m_owner = 0;   // 0 none, 1 fetch, 2 load/store
    int         m_age   = 0;   // cycles already spent outstanding
    bit         m_kill  = 0;   // fetch result no longer wanted
    bit         m_start = 0;
    bit         m_err   = 0;
    longint     m_pm = 0, m_pl = 0, m_pi = 0;
    bit         t_mem, t_ld, t_if, e_flush, e_ok;
    logic [5:0] e_stall;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bool_terms: begin
            t_mem = mem_req && !(m_owner == 2 && port_done);
            t_ld  = id_ld_use;
            t_if  = if_req && !(m_owner == 1 && port_done && !m_kill);
        end
        e_stall = 6'b0;
        if (t_mem) e_stall = e_stall | 6'b011111;
        if (t_ld)  e_stall = e_stall | 6'b000111;
        if (t_if)  e_stall = e_stall | 6'b000011;
        e_flush = ex_br_flush && !e_stall[4];
        e_ok    = (m_owner == 1) && port_done && !m_kill && !e_flush;
    endtask

    task automatic check_model();
        model_eval();
        chk6 ("stall",      stall_sign, e_stall);
        chk1 ("flush",      flush,      e_flush);
        chk1 ("if_data_ok", if_data_ok, e_ok);
        chk1 ("port_start", port_start, m_start);
        chk1 ("grant_if",   grant_if,   m_owner == 1);
        chk1 ("grant_mem",  grant_mem,  m_owner == 2);
        chk1 ("port_err",   port_err,   m_err);
`ifdef STALL_PERF_EN
        chk32("perf_mem", perf_mem_stall, 32'(m_pm));
        chk32("perf_ld",  perf_ld_stall,  32'(m_pl));
        chk32("perf_if",  perf_if_stall,  32'(m_pi));
`endif
    endtask

    task automatic model_update();
        model_eval();
        if (rst) begin
            m_owner = 0; m_age = 0; m_kill = 0; m_start = 0; m_err = 0;
            m_pm = 0; m_pl = 0; m_pi = 0;
        end else begin
            if (t_mem && m_pm < 64'hFFFF_FFFF) m_pm++;
            if (t_ld  && m_pl < 64'hFFFF_FFFF) m_pl++;
            if (t_if  && m_pi < 64'hFFFF_FFFF) m_pi++;
            m_start = 0;
            m_err   = 0;
            if (m_owner == 0) begin
                if (mem_req) begin
                    m_owner = 2; m_age = 0; m_start = 1;
                end else if (if_req) begin
                    m_owner = 1; m_age = 0; m_start = 1;
                end
            end else if (port_done) begin
                m_owner = 0; m_kill = 0;
            end else if (m_age + 1 == TO_CYC) begin
                m_owner = 0; m_kill = 0; m_err = 1;
            end else begin
                m_age++;
                if (m_owner == 1 && e_flush) m_kill = 1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_model();
        tick();
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 3 units later
    task automatic drive(input logic r, input logic i, input logic m,
                         input logic l, input logic b, input logic d);
        rst = r; if_req = i; mem_req = m; id_ld_use = l; ex_br_flush = b; port_done = d;
        #3;
    endtask

    int starts;
    int gm_cycles;

    initial begin
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; id_ld_use = 1'b0;
        ex_br_flush = 1'b0; port_done = 1'b0;
        @(posedge clk);
        #1;

        // reset
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk6("rst_stall", stall_sign, 6'b0);
        chk1("rst_grant_mem", grant_mem, 1'b0);
        step();

        // plain fetch, done on the fourth stalled-request cycle
        starts = 0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 0, 0, 0, 0);
            chk6("s1_stall", stall_sign, 6'b000011);
            starts += int'(port_start);
            step();
        end
        drive(0, 1, 0, 0, 0, 1);
        chk1("s1_ok", if_data_ok, 1'b1);
        chk6("s1_stall_done", stall_sign, 6'b0);
        starts += int'(port_start);
        step();
        drive(0, 0, 0, 0, 0, 0);
        starts += int'(port_start);
        step();
        chk32("s1_starts", 32'(starts), 32'd1);

        // MEM beats IF in IDLE, then IF is serviced
        drive(0, 1, 1, 0, 0, 0);
        chk6("s2_stall_req", stall_sign, 6'b011111);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(0, 1, 1, 0, 0, 0);
            chk1("s2_grant_mem", grant_mem, 1'b1);
            chk1("s2_grant_if", grant_if, 1'b0);
            chk6("s2_stall_lsu", stall_sign, 6'b011111);
            step();
        end
        drive(0, 1, 1, 0, 0, 1);
        chk6("s2_stall_done", stall_sign, 6'b000011);
        step();
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 0);
        chk1("s2_fetch_grant", grant_if, 1'b1);
        chk1("s2_fetch_start", port_start, 1'b1);
        step();
        drive(0, 1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // flush during an outstanding fetch discards its data
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 1, 0);
        chk1("s3_flush", flush, 1'b1);
        step();
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0, 1);
        chk1("s3_discard_ok", if_data_ok, 1'b0);
        chk6("s3_stall", stall_sign, 6'b000011);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // branch held behind a pending load/store
        drive(0, 0, 1, 0, 0, 0);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 1, 0, 1, 0);
            chk1("s4_flush_held", flush, 1'b0);
            step();
        end
        drive(0, 0, 1, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1, 0);
        chk1("s4_flush_after", flush, 1'b1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();

        // watchdog expiry on a stuck load/store
        drive(0, 0, 1, 0, 0, 0);
        step();
        gm_cycles = 0;
        for (int c = 0; c < TO_CYC; c++) begin
            drive(0, 0, (c < TO_CYC - 1), 0, 0, 0);
            gm_cycles += int'(grant_mem);
            chk1("s5_no_err_yet", port_err, 1'b0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        chk1("s5_port_err", port_err, 1'b1);
        chk1("s5_grant_mem", grant_mem, 1'b0);
        step();
        chk32("s5_grant_cycles", 32'(gm_cycles), 32'(TO_CYC));
        drive(0, 0, 0, 0, 0, 0);
        chk1("s5_err_pulse", port_err, 1'b0);
        step();

        // reset in the middle of a load/store, then a stray done
        drive(0, 0, 1, 0, 0, 0);
        step();
        drive(0, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk1("s6_grant_mem", grant_mem, 1'b0);
        chk1("s6_port_start", port_start, 1'b0);
        chk1("s6_if_data_ok", if_data_ok, 1'b0);
        chk6("s6_stall", stall_sign, 6'b0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk1("s6_still_idle", grant_if | grant_mem, 1'b0);
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) < 3,
                  $urandom_range(0, 19) < 3,
                  $urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
